onehot_decoder_stream: RTL and testbench
========================================

Name: onehot_decoder_stream

Overview:
- Streaming binary-to-one-hot decoder: the inverse of the 8-to-3 encoder.
- Accepts N-bit binary codes over a valid/ready handshake and emits the 2^N-bit one-hot word through a registered 2-entry output buffer.
- Counts delivered words.
- Sits between code-producing logic and one-hot select consumers (mux selects, bank enables) that can stall.

Parameters:
- N, 3, code width; output width is 2^N (default 8).
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept in_code this cycle.
- in_code  input  N  binary code to decode.
- out_valid  output  1  out_onehot holds a valid word.
- out_ready  input  1  consumer accepts out_onehot this cycle.
- out_onehot  output  2^N  decoded word; bit in_code set, all others 0.
- out_code  output  N  original code for the word on out_onehot.
- count  output  CNT_W  number of completed output handshakes, mod 2^CNT_W.
- busy  output  1  buffer non-empty (out_valid mirror, for status).

Behaviour:
- **Interface:** one clock, clk; reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- **Reset** (rst_n=0 at a rising edge) sets:
  - buffer occupancy to 0;
  - out_valid=0, busy=0;
  - out_onehot=0, out_code=0;
  - count=0.
  - in_ready is 1 on the first cycle after reset is released. While rst_n=0, in_ready=0.
- **Accept/deliver:**
  - Accept happens when in_valid && in_ready at a rising edge.
  - Deliver happens when out_valid && out_ready at a rising edge.
- **Decode:** one-hot word = 1 << in_code, computed at accept. Each stored entry holds the code (N bits) and the one-hot word (2^N bits). Decode is exact for all 2^N codes; there are no invalid codes.
- **Buffer:**
  - 2-entry FIFO with occupancy 0, 1 or 2. This is the state: EMPTY, ONE, FULL.
  - in_ready = (occupancy != 2). It is combinational from registered occupancy only and never depends on out_ready; there is no pass-through when FULL.
  - out_valid = (occupancy != 0). out_onehot and out_code show the head entry and are driven from registers.
- **Latency:** an accept at edge k makes the word visible with out_valid=1 after edge k when EMPTY. Minimum latency is 1 cycle.
- **Transitions:**
  - EMPTY: accept -> ONE.
  - ONE: accept without deliver -> FULL; deliver without accept -> EMPTY; accept and deliver together -> ONE (the new word becomes head).
  - FULL: deliver -> ONE (second entry becomes head); accept is impossible.
- **Throughput:** sustained 1 word/cycle when out_ready is held at 1.
- **Ordering:** strict FIFO; words leave in accept order.
- **Stall stability:** while out_valid=1 and out_ready=0, out_onehot and out_code are held stable.
- **When out_valid=0:** out_onehot and out_code are driven to 0. A one-hot consumer must never see a stale select.
- **count:** increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0. It is unchanged on accept only.
- **Input ignored:** in_code is ignored when in_valid=0 or in_ready=0.
- **Reset mid-operation:** buffered words are discarded, not delivered, and count is cleared. A handshake coinciding with the reset edge has no effect.

Test Plan:
1. **Reset:** hold rst_n=0 for 3 cycles with in_valid=1, in_code=5 -> in_ready=0, out_valid=0, out_onehot=8'h00, count=0 throughout. After release, in_ready=1.
2. **Exhaustive decode:** out_ready=1; send codes 0..7 back-to-back -> out_onehot sequence 01,02,04,08,10,20,40,80 one cycle after each accept, out_code matching, out_valid continuously high for 8 cycles, count=8.
3. **Backpressure:** out_ready=0; send 3, 6, 1 -> 3 and 6 accepted, in_ready=0 after second accept, 1 held off. out_onehot=8'h08 stable. Raise out_ready -> deliver 08, 40, then 02 after 1 is accepted; count=3.
4. **Simultaneous push/pop in ONE:** occupancy 1 (code 2); assert in_valid (code 7) and out_ready the same cycle -> 8'h04 delivered, next head 8'h80, occupancy stays 1.
5. **Reset mid-operation:** FULL with codes 4, 5 -> pulse rst_n=0 one cycle -> out_valid=0, out_onehot=0, count=0, and neither word ever appears.
6. **Counter wrap:** CNT_W=4; deliver 17 words -> count reads 15 after the 15th word, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/onehot_decoder_stream.sv
// Streaming binary-to-one-hot decoder with a registered 2-entry output FIFO and a delivered-word counter.
// One cycle of latency when empty; in_ready depends only on occupancy, so a full buffer never passes input straight through.
module onehot_decoder_stream #(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2**N-1:0]    out_onehot,
  output logic [N-1:0]       out_code,
  output logic [CNT_W-1:0]   count,
  output logic               busy
);

  localparam int W = 2**N;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [N-1:0]     r_code_h;
  logic [N-1:0]     r_code_t;
  logic [W-1:0]     r_oh_h;
  logic [W-1:0]     r_oh_t;
  logic [CNT_W-1:0] r_count;

  logic             w_acc;
  logic             w_del;
  logic [W-1:0]     w_oh_new;

  assign w_oh_new   = {{(W-1){1'b0}}, 1'b1} << in_code;

  assign in_ready   = rst_n && (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign busy       = out_valid;
  assign w_acc      = in_valid && in_ready;
  assign w_del      = out_valid && out_ready;

  // Head registers are cleared whenever the buffer empties, so an idle output reads as zero.
  assign out_onehot = r_oh_h;
  assign out_code   = r_code_h;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_EMPTY;
      r_code_h <= '0;
      r_code_t <= '0;
      r_oh_h   <= '0;
      r_oh_t   <= '0;
      r_count  <= '0;
    end else begin
      if (w_del) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_code_h <= in_code;
            r_oh_h   <= w_oh_new;
            r_state  <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_del) begin
            r_code_h <= in_code;
            r_oh_h   <= w_oh_new;
          end else if (w_acc) begin
            r_code_t <= in_code;
            r_oh_t   <= w_oh_new;
            r_state  <= S_FULL;
          end else if (w_del) begin
            r_code_h <= '0;
            r_oh_h   <= '0;
            r_state  <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_del) begin
            r_code_h <= r_code_t;
            r_oh_h   <= r_oh_t;
            r_state  <= S_ONE;
          end
        end
        default: begin
          r_code_h <= '0;
          r_oh_h   <= '0;
          r_state  <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Bench for onehot_decoder_stream: a default instance and a CNT_W=4 instance share stimulus,
// both compared every cycle against a queue-based reference model.
module tb_onehot_decoder_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [7:0]  onehot_a;
  logic [2:0]  code_a;
  logic [15:0] count_a;

  logic        in_ready_b, out_valid_b, busy_b;
  logic [7:0]  onehot_b;
  logic [2:0]  code_b;
  logic [3:0]  count_b;

  logic [47:0] obs;

  int errors = 0;
  int checks = 0;

  int q[$];
  int mcount = 0;

  onehot_decoder_stream u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_a),
    .in_code    (in_code),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready),
    .out_onehot (onehot_a),
    .out_code   (code_a),
    .count      (count_a),
    .busy       (busy_a)
  );

  onehot_decoder_stream #(.N(3), .CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_b),
    .in_code    (in_code),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .out_onehot (onehot_b),
    .out_code   (code_b),
    .count      (count_b),
    .busy       (busy_b)
  );

  assign obs = {in_ready_a, out_valid_a, busy_a, onehot_a, code_a, count_a,
                in_ready_b, out_valid_b, busy_b, onehot_b, code_b, count_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  // Expected outputs of both instances from the model queue and delivered-word total.
  function automatic logic [47:0] exp_vec();
    logic       ir, ov;
    logic [7:0] oh;
    logic [2:0] oc;
    logic [15:0] c16;
    logic [3:0]  c4;
    ir  = rst_n && (q.size() < 2);
    ov  = (q.size() != 0);
    oh  = ov ? (8'd1 << q[0]) : 8'd0;
    oc  = ov ? 3'(q[0]) : 3'd0;
    c16 = 16'(mcount % 65536);
    c4  = 4'(mcount % 16);
    return {ir, ov, ov, oh, oc, c16, ir, ov, ov, oh, oc, c4};
  endfunction

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic tick();
    bit acc, del;
    acc = rst_n && in_valid && (q.size() < 2);
    del = rst_n && out_ready && (q.size() != 0);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      mcount = 0;
    end else begin
      if (del) begin
        void'(q.pop_front());
        mcount++;
      end
      if (acc) q.push_back(int'(in_code));
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_vec: got %h required %h", obs, exp_vec());
      end
      checks++;
      if ({in_ready_a, out_valid_a, onehot_a, count_a} !== 26'd0) begin
        errors++; $display("FAIL reset_outputs: got rdy=%b vld=%b oh=%h cnt=%0d required all 0",
                           in_ready_a, out_valid_a, onehot_a, count_a);
      end
      checks++;
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready_a);
    end
    checks++;
  endtask

  task automatic test_decode();
    logic [7:0] want;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_code = 3'(c);
      tick();
      want = 8'd1 << c;
      if (onehot_a !== want || code_a !== 3'(c) || out_valid_a !== 1'b1) begin
        errors++; $display("FAIL decode_word%0d: got oh=%h code=%0d vld=%b required oh=%h code=%0d vld=1",
                           c, onehot_a, code_a, out_valid_a, want, c);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL decode_vec: got %h required %h", obs, exp_vec());
      end
      checks++;
    end
    in_valid = 1'b0;
    tick();
    if (count_a !== 16'd8 || out_valid_a !== 1'b0 || onehot_a !== 8'h00) begin
      errors++; $display("FAIL decode_count: got cnt=%0d vld=%b oh=%h required cnt=8 vld=0 oh=00",
                         count_a, out_valid_a, onehot_a);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int base;
    base = mcount;
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd3; tick();
    in_code = 3'd6; tick();
    in_code = 3'd1;
    for (int i = 0; i < 3; i++) begin
      if (in_ready_a !== 1'b0 || onehot_a !== 8'h08 || code_a !== 3'd3) begin
        errors++; $display("FAIL bp_stall%0d: got rdy=%b oh=%h code=%0d required rdy=0 oh=08 code=3",
                           i, in_ready_a, onehot_a, code_a);
      end
      checks++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    if (onehot_a !== 8'h40 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL bp_second: got oh=%h rdy=%b required oh=40 rdy=1", onehot_a, in_ready_a);
    end
    checks++;
    tick();
    in_valid = 1'b0;
    if (onehot_a !== 8'h02 || code_a !== 3'd1) begin
      errors++; $display("FAIL bp_third: got oh=%h code=%0d required oh=02 code=1", onehot_a, code_a);
    end
    checks++;
    tick();
    if (32'(count_a) - 32'(base) !== 32'd3 || out_valid_a !== 1'b0) begin
      errors++; $display("FAIL bp_count: got delta=%0d vld=%b required delta=3 vld=0",
                         32'(count_a) - 32'(base), out_valid_a);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL bp_vec: got %h required %h", obs, exp_vec());
    end
    checks++;
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd2; tick();
    if (onehot_a !== 8'h04 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL simul_one: got oh=%h rdy=%b required oh=04 rdy=1", onehot_a, in_ready_a);
    end
    checks++;
    in_code = 3'd7; out_ready = 1'b1; tick();
    in_valid = 1'b0; out_ready = 1'b0;
    if (onehot_a !== 8'h80 || code_a !== 3'd7 || in_ready_a !== 1'b1 || out_valid_a !== 1'b1) begin
      errors++; $display("FAIL simul_head: got oh=%h code=%0d rdy=%b vld=%b required oh=80 code=7 rdy=1 vld=1",
                         onehot_a, code_a, in_ready_a, out_valid_a);
    end
    checks++;
    tick();
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL simul_vec: got %h required %h", obs, exp_vec());
    end
    checks++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'd4; tick();
    in_code = 3'd5; tick();
    in_valid = 1'b0;
    if (in_ready_a !== 1'b0 || onehot_a !== 8'h10) begin
      errors++; $display("FAIL mid_full: got rdy=%b oh=%h required rdy=0 oh=10", in_ready_a, onehot_a);
    end
    checks++;
    rst_n = 1'b0; out_ready = 1'b1; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid_a !== 1'b0 || onehot_a !== 8'h00 || count_a !== 16'd0) begin
        errors++; $display("FAIL mid_cleared%0d: got vld=%b oh=%h cnt=%0d required vld=0 oh=00 cnt=0",
                           i, out_valid_a, onehot_a, count_a);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    int delivered;
    delivered = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 18; t++) begin
      in_valid = (t < 17); in_code = 3'(t);
      tick();
      if (t > 0) delivered++;
      if (delivered >= 15 && delivered <= 17) begin
        if (count_b !== 4'(delivered % 16)) begin
          errors++; $display("FAIL wrap_after%0d: got %0d required %0d", delivered, count_b, delivered % 16);
        end
        checks++;
      end
    end
    in_valid = 1'b0;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL wrap_vec: got %h required %h", obs, exp_vec());
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      #1;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_vec%0d: got %h required %h", i, obs, exp_vec());
      end
      checks++;
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b0;
    test_reset();
    test_decode();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
